// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_if.sv
// Handshake and operand bus for serial_sub.
// Optional: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave  (input start, a, b, bin, output busy, done, d, bout);
`endif

endinterface

// File: rtl/serial_sub_full_subtractor_1.sv
// One-bit full subtractor: o_d = i_a - i_b - i_bin, o_bout is the borrow out.
module full_subtractor_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    // Borrow when b alone exceeds a, or when a == b and a borrow comes in.
    always_comb begin
        o_d    = i_a ^ i_b ^ i_bin;
        o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, d = a - b - bin, LSB first through one full-subtractor cell.
// Optional: SERIAL_SUB_OVF_EN adds a registered signed-overflow output (bus.ovf).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CntW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;

    logic             w_diff;
    logic             w_bout;
    logic             w_last;

    full_subtractor_1 u_fs (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_borrow),
        .o_d    (w_diff),
        .o_bout (w_bout)
    );

    assign w_last = (r_cnt == CntW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are captured at start because the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == StIdle && bus.start) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (r_state == StShift && w_last) begin
            // w_diff is the result MSB on the final step.
            r_ovf <= (r_a_msb ^ r_b_msb) & (w_diff ^ r_a_msb);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a_sr   <= bus.a;
                        r_b_sr   <= bus.b;
                        r_borrow <= bus.bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= StShift;
                    end
                end
                StShift: begin
                    r_borrow <= w_bout;
                    r_res    <= {w_diff, r_res[WIDTH-1:1]};
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_d     <= {w_diff, r_res[WIDTH-1:1]};
                        r_bout  <= w_bout;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.d    = r_d;
    assign bus.bout = r_bout;

endmodule
